// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing-checksum state ST_CHK.
package loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK   = 3'd4,
`endif
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_ready flags the 4th byte
// combinationally so the caller can capture `word` on that same edge.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  // Only the three oldest bytes need storage; the fourth is the live input.
  logic [WORD_W-BYTE_W-1:0] shreg;
  logic [1:0]               cnt;

  assign word       = {shreg, byte_in};
  assign word_ready = shift_en && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      shreg <= word[WORD_W-BYTE_W-1:0];
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Host byte stream -> IMEM word writes, holding the CPU in reset during a load.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [31:0] MAX_WORDS = 32'(DEPTH - BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t ST_FINAL = ST_CHK;
`else
  localparam state_t ST_FINAL = ST_DONE;
`endif

  state_t      state, state_nx;
  logic [31:0] n_words;
  logic [31:0] word_idx;
  logic [31:0] len_word, data_word;
  logic        len_ready, data_ready;
  logic        byte_fire, start_ok, len_shift, data_shift, last_word;

  assign byte_fire  = byte_valid && byte_ready;
  assign start_ok   = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign len_shift  = byte_fire && (state == ST_LEN);
  assign data_shift = byte_fire && (state == ST_DATA);
  assign last_word  = (word_idx + 32'd1) == n_words;

  byte_packer u_len_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .shift_en   (len_shift),
    .byte_in    (byte_data),
    .word       (len_word),
    .word_ready (len_ready)
  );

  byte_packer u_data_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .shift_en   (data_shift),
    .byte_in    (byte_data),
    .word       (data_word),
    .word_ready (data_ready)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           chk_acc <= '0;
    else if (start_ok)   chk_acc <= '0;
    else if (data_shift) chk_acc <= chk_acc ^ byte_data;
  end
`endif

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        load_done  = (state == ST_DONE);
        load_error = (state == ST_ERR);
        if (start) state_nx = ST_LEN;
      end
      ST_LEN: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (len_ready) begin
          if (len_word == '0)           state_nx = ST_FINAL;
          else if (len_word > MAX_WORDS) state_nx = ST_ERR;
          else                          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (data_ready) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        cpu_hold = 1'b1;
        state_nx = last_word ? ST_FINAL : ST_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_fire) state_nx = (byte_data == chk_acc) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // The write strobe and payload are registered on the 4th data byte, so they
  // appear exactly during the single WRITE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      n_words    <= '0;
      word_idx   <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= ADDR_W'(BASE_ADDR);
      imem_wdata <= '0;
    end else begin
      state   <= state_nx;
      imem_we <= 1'b0;
      if (start_ok) begin
        n_words  <= '0;
        word_idx <= '0;
      end
      if (len_ready) n_words <= len_word;
      if (data_ready) begin
        imem_we    <= 1'b1;
        imem_wdata <= data_word;
        imem_waddr <= ADDR_W'(BASE_ADDR + word_idx);
      end
      if (state == ST_WRITE) word_idx <= word_idx + 32'd1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed table-driven bench for imem_loader (DEPTH=256, BASE_ADDR=0).
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset, start, byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready, imem_we, cpu_hold, load_done, load_error;
  logic [7:0] imem_waddr;
  logic [31:0] imem_wdata;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  typedef struct {
    logic [127:0] bytes;      // stream, left-justified, byte 0 first
    int           nbytes;
    int           gap;
    int           exp_writes;
    logic [63:0]  words;      // expected word 0 then word 1
    logic         exp_done;
    logic         exp_err;
  } case_t;

  case_t cases[6];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [7:0]  wr_addr[4];
  logic [31:0] wr_data[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_cnt < 4) begin
        wr_addr[wr_cnt] = imem_waddr;
        wr_data[wr_cnt] = imem_wdata;
      end
      wr_cnt++;
      chk("byte_ready_in_write", {31'd0, byte_ready}, 32'd0);
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start  = 1'b1;
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    chk("cpu_hold_after_start", {31'd0, cpu_hold}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) chk("byte_accept_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 30; i++) begin
      if (load_done || load_error) break;
      @(negedge clk);
    end
  endtask

  task automatic check_end(input string tag, input int nw, input logic [63:0] words,
                           input logic done, input logic err);
    chk({tag, "_done"},  {31'd0, load_done},  {31'd0, done});
    chk({tag, "_error"}, {31'd0, load_error}, {31'd0, err});
    chk({tag, "_hold"},  {31'd0, cpu_hold},   32'd0);
    chk({tag, "_nwrites"}, wr_cnt, nw);
    for (int j = 0; j < nw && j < 2; j++) begin
      chk({tag, "_addr"}, {24'd0, wr_addr[j]}, j);
      chk({tag, "_data"}, wr_data[j], words[63-32*j -: 32]);
    end
  endtask

  task automatic send_range(input logic [127:0] bytes, input int from, input int to,
                            input int gap);
    for (int i = from; i < to; i++) send_byte(bytes[127-8*i -: 8], gap);
  endtask

  function automatic logic [7:0] xor_data(input logic [127:0] bytes, input int nbytes);
    logic [7:0] cs = 8'h00;
    for (int i = 4; i < nbytes; i++) cs ^= bytes[127-8*i -: 8];
    return cs;
  endfunction

  task automatic run_case(input case_t c, input string tag);
    pulse_start();
    send_range(c.bytes, 0, c.nbytes, c.gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!c.exp_err) send_byte(xor_data(c.bytes, c.nbytes), c.gap);
`endif
    wait_end();
    check_end(tag, c.exp_writes, c.words, c.exp_done, c.exp_err);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_imem_we"},    {31'd0, imem_we},    32'd0);
    chk({tag, "_waddr"},      {24'd0, imem_waddr}, 32'd0);
    chk({tag, "_wdata"},      imem_wdata,          32'd0);
    chk({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd0);
    chk({tag, "_done"},       {31'd0, load_done},  32'd0);
    chk({tag, "_error"},      {31'd0, load_error}, 32'd0);
  endtask

  initial begin
    cases[0] = '{bytes: 128'h00000002_20080005_01095020_00000000, nbytes: 12, gap: 0,
                 exp_writes: 2, words: 64'h20080005_01095020, exp_done: 1, exp_err: 0};
    cases[1] = '{bytes: 128'h00000002_20080005_01095020_00000000, nbytes: 12, gap: 3,
                 exp_writes: 2, words: 64'h20080005_01095020, exp_done: 1, exp_err: 0};
    cases[2] = '{bytes: 128'h00000101_00000000_00000000_00000000, nbytes: 4, gap: 0,
                 exp_writes: 0, words: 64'h0, exp_done: 0, exp_err: 1};
    cases[3] = '{bytes: 128'h00000000_00000000_00000000_00000000, nbytes: 4, gap: 0,
                 exp_writes: 0, words: 64'h0, exp_done: 1, exp_err: 0};
    cases[4] = '{bytes: 128'h00000001_DEADBEEF_00000000_00000000, nbytes: 8, gap: 1,
                 exp_writes: 1, words: 64'hDEADBEEF_00000000, exp_done: 1, exp_err: 0};
    cases[5] = '{bytes: 128'h01000000_00000000_00000000_00000000, nbytes: 4, gap: 2,
                 exp_writes: 0, words: 64'h0, exp_done: 0, exp_err: 1};

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    for (int n = 0; n < 6; n++) run_case(cases[n], $sformatf("case%0d", n));

    // Reset in the middle of a load, then a complete reload.
    pulse_start();
    send_range(cases[0].bytes, 0, 6, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    run_case(cases[0], "reload");

    // A start pulse during DATA must not restart the load.
    pulse_start();
    send_range(cases[0].bytes, 0, 5, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
    send_range(cases[0].bytes, 5, 12, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xor_data(cases[0].bytes, 12), 0);
`endif
    wait_end();
    check_end("restart", 2, 64'h20080005_01095020, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_range(128'h00000001_AABBCCDD_00000000_00000000, 0, 8, 0);
    send_byte(8'h00, 0);
    wait_end();
    check_end("cks_ok", 1, 64'hAABBCCDD_00000000, 1'b1, 1'b0);

    pulse_start();
    send_range(128'h00000001_AABBCCDD_00000000_00000000, 0, 8, 0);
    send_byte(8'h01, 0);
    wait_end();
    check_end("cks_bad", 1, 64'hAABBCCDD_00000000, 1'b0, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream from a host link (valid/ready), packs it into 32-bit instruction words, and writes them into the IMEM write port at consecutive word addresses.
- Holds the CPU (PC) in reset while loading, so fetch never sees a half-written program.
- Sits between the host/UART byte source and the IMEM write port. Its `cpu_hold` output is ORed into the PC reset.

Parameters:
- ADDR_W, 8, width of the IMEM word address.
- DEPTH, 256, number of IMEM words; must be ≤ 2**ADDR_W.
- BASE_ADDR, 0, first word address written.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a load.
- byte_valid  in  1  host byte present.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts byte this cycle; a transfer occurs when byte_valid && byte_ready.
- imem_we  out  1  IMEM write strobe, one cycle per word.
- imem_waddr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  instruction word.
- cpu_hold  out  1  high while loading; keeps the PC in reset.
- load_done  out  1  level; load finished OK.
- load_error  out  1  level; load aborted.

Behaviour:
- Reset values: byte_ready=0, imem_we=0, imem_waddr=BASE_ADDR, imem_wdata=0, cpu_hold=0, load_done=0, load_error=0, state=IDLE.
- Stream format: 4-byte word count N, big-endian. Then N words, each 4 bytes, MSB first. The first byte of a word lands in [31:24], which contains the opcode [31:26].
- FSM: IDLE, LEN, DATA, WRITE, (CHK), DONE, ERR.
- IDLE/DONE/ERR + start → LEN.
  - Clears load_done, load_error, the byte counter, the word index and the checksum.
  - cpu_hold=1 from the cycle after start.
  - start in LEN/DATA/WRITE/CHK is ignored.
- LEN: byte_ready=1. After the 4th accepted byte, N is registered, then:
  - N=0 → DONE (or CHK if enabled).
  - N > DEPTH-BASE_ADDR → ERR.
  - otherwise → DATA.
- DATA: byte_ready=1. Bytes shift into a 32-bit assembly register (left shift by 8, new byte in [7:0]). The 4th accepted byte → WRITE.
- WRITE: exactly 1 cycle.
  - imem_we=1, imem_waddr=BASE_ADDR+k, imem_wdata=assembled word, byte_ready=0.
  - Write latency is 1 cycle after the 4th byte handshake.
  - Then k++. If k reaches N → DONE (or CHK); else → DATA.
- DONE: cpu_hold=0, load_done=1, byte_ready=0.
- ERR: cpu_hold=0, load_error=1, byte_ready=0. No further writes occur.
- imem_we is 0 in every state except WRITE. imem_waddr/imem_wdata hold their last values otherwise.
- Word index and address never wrap: the overflow check in LEN guarantees BASE_ADDR+N-1 ≤ DEPTH-1.
- byte_valid with byte_ready=0: the byte is not consumed, and the host must hold it.
- Reset asserted mid-load: asynchronous return to reset values. The partially written IMEM content is left as is.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: after the last data word (or after LEN when N=0), state CHK accepts one byte.
  - Expected value: XOR of all data bytes (length bytes excluded).
  - Match → DONE; mismatch → ERR.
- Undefined: no CHK state; the transition is directly to DONE and the stream has no trailing byte.

Decomposition:
- Package loader_pkg: state encoding localparams, BYTES_PER_WORD=4, WORD_W=32.
- Sub-module byte_packer: 8→32 shift register plus 2-bit byte counter, with a word_ready pulse. It is instantiated twice: once for the length, once for data words.

Test Plan:
- Reset, then start, then stream 00 00 00 02 | 20 08 00 05 | 01 09 50 20:
  - imem_we pulses twice: addr 0 = 0x20080005, addr 1 = 0x01095020.
  - load_done=1, cpu_hold=0.
- Byte-valid gaps (byte_valid low 3 cycles between bytes) → same writes and same data; byte_ready=0 during each WRITE cycle.
- Length 0x00000101 with DEPTH=256 → load_error=1, no imem_we, cpu_hold=0.
- reset asserted after the 6th byte → all outputs at reset values immediately. A new start with a full stream then loads correctly.
- start pulse during DATA → ignored; the load completes with the original N.
- With IMEM_LOADER_CHECKSUM_EN, N=1, word 0xAABBCCDD:
  - checksum 0x00 → load_done.
  - checksum 0x01 → load_error, with the word still written at addr 0.
